modport_fifo: RTL and testbench
===============================

MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of storage entries; it must be a power of two, at least 2.
REQ-003 The block SHALL have localparam ADDR_W = $clog2(DEPTH), giving the pointer width.
Ports (name, direction, width, meaning):
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 Port wr_n, input, 1 bit: write strobe, active-low, sampled at the rising edge of clk.
REQ-007 Port rd_n, input, 1 bit: read strobe, active-low, sampled at the rising edge of clk.
REQ-008 Port din, input, DATA_W bits: write data, captured when a write is accepted.
REQ-009 Port dout, output, DATA_W bits: registered read data.
REQ-010 Port full, output, 1 bit: registered; 1 when the FIFO holds DEPTH entries.
REQ-011 Port empty, output, 1 bit: registered; 1 when the FIFO holds 0 entries.

Function
REQ-012 Ordering SHALL be first-in first-out; entries are never reordered, duplicated or dropped, except for writes rejected under REQ-014.
REQ-013 A write SHALL be accepted on a rising edge when wr_n==0 and full==0 before that edge: mem[wptr] <= din and wptr advances by 1.
REQ-014 A write attempted while full==1 SHALL be ignored: no storage change, no pointer change, no error output.
REQ-015 A read SHALL be accepted on a rising edge when rd_n==0 and empty==0 before that edge: dout <= mem[rptr] and rptr advances by 1.
REQ-016 Read latency SHALL be one cycle: data is valid on dout immediately after the accepting edge.
REQ-017 dout SHALL hold its last value when no read is accepted, including a read attempted while empty.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 An occupancy counter of ADDR_W+1 bits SHALL track the entry count, range 0..DEPTH.
REQ-020 The counter SHALL change as follows per edge: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-021 Simultaneous wr_n==0 and rd_n==0 with 0<count<DEPTH SHALL perform both operations; count is unchanged.
REQ-022 Simultaneous strobes with empty==1 SHALL perform only the write; afterwards count is 1, empty is 0 and dout is unchanged.
REQ-023 Simultaneous strobes with full==1 SHALL perform only the read; afterwards count is DEPTH-1 and full is 0.
REQ-024 full and empty SHALL be registered and updated on the same edge as the counter: full=(next count==DEPTH), empty=(next count==0).
REQ-025 full and empty SHALL never both be 1.

Reset
REQ-026 When rst==1 at a rising edge, wptr, rptr and count SHALL become 0, dout SHALL become 0, empty SHALL become 1 and full SHALL become 0.
REQ-027 Reset SHALL take priority over any simultaneous strobe; a reset mid-operation discards all stored entries.
REQ-028 Memory contents SHALL NOT be cleared by reset; stale data must be unreachable because empty==1.

Structure
REQ-029 Package fifo_pkg SHALL hold DATA_W and DEPTH defaults and a data typedef data_t (logic [DATA_W-1:0]).
REQ-030 Storage SHALL be one sub-module, fifo_mem: a 1-write/1-read-port register array, synchronous write, combinational read address.
REQ-031 Pointer, counter, flag and dout logic SHALL reside in modport_fifo.

Verification
REQ-032 Reset check: assert rst for 2 cycles -> empty=1, full=0, dout=8'h00.
REQ-033 Fill and drain: write 8'h00..8'h0F -> full=1 after the 16th write; then 16 reads return 8'h00..8'h0F in order, with empty=1 after the last read.
REQ-034 Overflow and underflow: a 17th write of 8'hAA while full is dropped, and the next 16 reads contain no 8'hAA; a read while empty leaves dout at its last value, and flags are unchanged.
REQ-035 Simultaneous strobes at count 5 for 10 cycles -> count stays 5, and read data follows write data with a 5-entry delay.
REQ-036 Boundary strobes: both strobes while empty -> count 1, dout unchanged; both strobes while full -> count 15, full=0.
REQ-037 Wrap-around and mid-operation reset: 40 random interleaved operations are compared against a queue model; then a reset asserted with 7 entries stored -> empty=1, and a subsequent write/read of 8'h5C returns 8'h5C.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and data type for the modport_fifo codebase slice.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one combinational read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Storage is deliberately not reset; the empty flag fences off stale entries.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/modport_fifo.sv
// Synchronous FIFO with active-low strobes, registered dout and registered full/empty.
module modport_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Acceptance uses the registered flags, so a full FIFO still reads and an empty one still writes.
    assign wr_acc = !wr_n && !full_q;
    assign rd_acc = !rd_n && !empty_q;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_q),
        .wdata (din),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;

        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
            dout_d = mem_rdata;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo: hand-computed vectors plus a queue model for the mixed run.
module tb_modport_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       full;
    logic       empty;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] model_q [$];
    logic [7:0] model_dout = 8'h00;

    modport_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_n  (wr_n),
        .rd_n  (rd_n),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given strobes; the queue model tracks accepted operations.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic wa;
        logic ra;
        wr_n = !w;
        rd_n = !r;
        din  = d;
        wa = w && (model_q.size() < 16);
        ra = r && (model_q.size() > 0);
        @(posedge clk);
        if (ra) model_dout = model_q.pop_front();
        if (wa) model_q.push_back(d);
        #1;
        wr_n = 1'b1;
        rd_n = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        model_q.delete();
        model_dout = 8'h00;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset
        do_reset(2);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_dout", 32'(dout), 32'h00);

        // Fill 00..0F
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 0)  chk("fill_first_empty", 32'(empty), 32'h0);
            if (i == 14) chk("fill_15_full", 32'(full), 32'h0);
        end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_empty", 32'(empty), 32'h0);

        // Overflow write is dropped
        step(1'b1, 1'b0, 8'hAA);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_count", 32'(dut.count_q), 32'd16);

        // Drain in order, no AA
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain_%0d", i), 32'(dout), 32'(i));
            if (i == 14) chk("drain_15_empty", 32'(empty), 32'h0);
        end
        chk("drain_empty", 32'(empty), 32'h1);
        chk("drain_full", 32'(full), 32'h0);

        // Underflow read holds dout and flags
        step(1'b0, 1'b1, 8'h00);
        chk("udf_dout", 32'(dout), 32'h0F);
        chk("udf_empty", 32'(empty), 32'h1);
        chk("udf_full", 32'(full), 32'h0);

        // Simultaneous strobes at count 5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
        chk("sim_pre_count", 32'(dut.count_q), 32'd5);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 8'h30 + 8'(k));
            chk($sformatf("sim_dout_%0d", k), 32'(dout),
                (k < 5) ? 32'h20 + 32'(k) : 32'h30 + 32'(k - 5));
            chk($sformatf("sim_count_%0d", k), 32'(dut.count_q), 32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("sim_tail_%0d", i), 32'(dout), 32'h35 + 32'(i));
        end
        chk("sim_tail_empty", 32'(empty), 32'h1);

        // Both strobes while empty: only the write happens
        step(1'b1, 1'b1, 8'h77);
        chk("bemp_dout", 32'(dout), 32'h39);
        chk("bemp_count", 32'(dut.count_q), 32'd1);
        chk("bemp_empty", 32'(empty), 32'h0);
        step(1'b0, 1'b1, 8'h00);
        chk("bemp_read", 32'(dout), 32'h77);
        chk("bemp_read_empty", 32'(empty), 32'h1);

        // Both strobes while full: only the read happens
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
        chk("bful_pre_full", 32'(full), 32'h1);
        step(1'b1, 1'b1, 8'h99);
        chk("bful_dout", 32'(dout), 32'h80);
        chk("bful_count", 32'(dut.count_q), 32'd15);
        chk("bful_full", 32'(full), 32'h0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("bful_drain_%0d", i), 32'(dout), 32'h80 + 32'(i));
        end
        chk("bful_drain_empty", 32'(empty), 32'h1);

        // Random interleaved operations against the queue model
        for (int i = 0; i < 40; i++) begin
            logic w;
            logic r;
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 45);
            step(w, r, 8'($urandom_range(0, 255)));
            chk($sformatf("rnd_dout_%0d", i), 32'(dout), 32'(model_dout));
            chk($sformatf("rnd_empty_%0d", i), 32'(empty), 32'(model_q.size() == 0));
            chk($sformatf("rnd_full_%0d", i), 32'(full), 32'(model_q.size() == 16));
        end

        // Reset with 7 entries stored
        do_reset(1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
        chk("mrst_pre_count", 32'(dut.count_q), 32'd7);
        wr_n = 1'b0;
        rd_n = 1'b0;
        din  = 8'hEE;
        do_reset(1);
        wr_n = 1'b1;
        rd_n = 1'b1;
        chk("mrst_empty", 32'(empty), 32'h1);
        chk("mrst_full", 32'(full), 32'h0);
        chk("mrst_dout", 32'(dout), 32'h00);
        chk("mrst_count", 32'(dut.count_q), 32'd0);
        step(1'b1, 1'b0, 8'h5C);
        chk("mrst_wr_empty", 32'(empty), 32'h0);
        step(1'b0, 1'b1, 8'h00);
        chk("mrst_rd_dout", 32'(dout), 32'h5C);
        chk("mrst_rd_empty", 32'(empty), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
